// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// dmem_if : request/response bundle between MEM stage and dmem_ctrl
// Rev 1.0
// ============================================================================
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : RV32I byte-addressed little-endian data memory, one access in flight
// Rev 1.0
// ============================================================================
module dmem_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_if.slave     bus
);
  localparam int                MEM_AW  = $clog2(DEPTH_BYTES);
  localparam logic [2:0]        C_LAT   = 3'(READ_LAT);
  localparam logic [MEM_AW-1:0] C_WMASK = ~MEM_AW'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept_w, f3_ok_w, misalign_w, oor_w, req_err_w, wr_w;
  logic [1:0]        size_w;
  logic [3:0]        lane_en_w;
  logic [MEM_AW-1:0] wbase_w, rbase_w;
  logic [31:0]       wshift_w, ld_word_w, ld_shift_w, ld_ext_w;

  // Request decode works on the live bus so stores can commit on the accept edge.
  always_comb begin
    lane_en_w  = '0;
    accept_w   = bus.req_valid && (state_q == S_IDLE);
    size_w     = bus.req_funct3[1:0];
    f3_ok_w    = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign_w = ((size_w == 2'b01) && bus.req_addr[0]) ||
                 ((size_w == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    oor_w      = |bus.req_addr[ADDR_W-1:MEM_AW];
    req_err_w  = !f3_ok_w || misalign_w || oor_w;
    wr_w       = accept_w && !rst && bus.req_we && !req_err_w;
    wbase_w    = bus.req_addr[MEM_AW-1:0] & C_WMASK;
    wshift_w   = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
    for (int k = 0; k < 4; k++) begin
      lane_en_w[k] = wr_w && ((size_w == 2'b10) ||
                              ((size_w == 2'b01) && (bus.req_addr[1] == (k > 1))) ||
                              ((size_w == 2'b00) && (bus.req_addr[1:0] == 2'(k))));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_en_w[k]) mem[wbase_w | MEM_AW'(k)] <= wshift_w[8*k +: 8];
    end
  end

  always_comb begin
    rbase_w    = addr_q & C_WMASK;
    ld_word_w  = {mem[rbase_w | MEM_AW'(3)], mem[rbase_w | MEM_AW'(2)],
                  mem[rbase_w | MEM_AW'(1)], mem[rbase_w]};
    ld_shift_w = ld_word_w >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext_w = {{24{ld_shift_w[7]}}, ld_shift_w[7:0]};
      3'b001:  ld_ext_w = {{16{ld_shift_w[15]}}, ld_shift_w[15:0]};
      3'b010:  ld_ext_w = ld_shift_w;
      3'b100:  ld_ext_w = {24'h0, ld_shift_w[7:0]};
      3'b101:  ld_ext_w = {16'h0, ld_shift_w[15:0]};
      default: ld_ext_w = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          state_d = S_ACCESS;
          cnt_d   = 3'd1;
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr[MEM_AW-1:0];
          err_d   = req_err_w;
        end
      end
      S_ACCESS: begin
        if (cnt_q == C_LAT) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (err_q || we_q) ? 32'h0 : ld_ext_w;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          cnt_d       = 3'd0;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_ctrl : randomized bench for dmem_ctrl against a byte-array memory model
// Rev 1.0
// ============================================================================
module tb_dmem_ctrl;
  localparam int DEPTH    = 1024;
  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  mem_m [DEPTH];
  logic        exp_err;
  logic [31:0] exp_rdata;

  dmem_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(
    .DEPTH_BYTES (DEPTH),
    .ADDR_W      (32),
    .READ_LAT    (READ_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: access size is 1<<funct3[1:0] bytes; alignment and range are plain arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int   sz;
    logic legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz    = 1 << f3[1:0];
    err   = !legal || ((addr % sz) != 0) || (addr >= DEPTH);
    rd    = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mem_m[addr + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[addr + i];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      chk("rsp_rdata_vs_model", bus.rsp_rdata, exp_rdata);
      chk("rsp_err_vs_model", 32'(bus.rsp_err), 32'(exp_err));
    end
  end

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model(we, f3, addr, wd, exp_err, exp_rdata);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", n, READ_LAT);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rd);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h0;
    exp_err = 1'b0; exp_rdata = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    // Clear a known window so random loads never depend on power-up RAM contents.
    for (int a = 0; a < 128; a += 4) xact(1'b1, 3'd2, 32'(a), 32'h0, 0, rd, er);

    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);
    chk("t1_err", 32'(er), 32'd0);
    xact(1'b0, 3'd0, 32'h10, 32'h0, 1, rd, er); chk("t2_lb", rd, 32'hFFFFFFEF);
    xact(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er); chk("t2_lbu", rd, 32'h000000DE);
    xact(1'b0, 3'd1, 32'h12, 32'h0, 2, rd, er); chk("t2_lh", rd, 32'hFFFFDEAD);
    xact(1'b0, 3'd5, 32'h12, 32'h0, 0, rd, er); chk("t2_lhu", rd, 32'h0000DEAD);
    xact(1'b1, 3'd0, 32'h11, 32'h123456AA, 0, rd, er);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er); chk("t3_lw", rd, 32'hDEADAAEF);

    xact(1'b0, 3'd2, 32'h12, 32'h0, 0, rd, er);
    chk("t4_misalign_err", 32'(er), 32'd1); chk("t4_misalign_rdata", rd, 32'h0);
    xact(1'b1, 3'd1, 32'h401, 32'hFFFFFFFF, 0, rd, er); chk("t4_sh_oor_err", 32'(er), 32'd1);
    xact(1'b0, 3'd2, 32'h400, 32'h0, 0, rd, er); chk("t4_lw_oor_err", 32'(er), 32'd1);
    xact(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er); chk("t4_f3_err", 32'(er), 32'd1);
    xact(1'b1, 3'd3, 32'h10, 32'h0, 0, rd, er); chk("t4_st_f3_err", 32'(er), 32'd1);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er); chk("t4_unchanged", rd, 32'hDEADAAEF);

    xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er); chk("t5_held_lw", rd, 32'hDEADAAEF);

    // Reset while the store response is still pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model(1'b1, 3'd2, 32'h20, 32'h55, exp_err, exp_rdata);
    chk("t6_in_access", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("t6_discarded", 32'(bus.rsp_valid), 32'd0);
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er); chk("t6_lw", rd, 32'h00000055);

    // A request presented together with reset is ignored.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h30; bus.req_wdata = 32'hABABABAB;
    @(posedge clk); #1;
    rst = 1'b0; bus.req_valid = 1'b0;
    chk("rstreq_ready", 32'(bus.req_ready), 32'd1);
    repeat (READ_LAT + 1) @(posedge clk);
    #1;
    chk("rstreq_no_rsp", 32'(bus.rsp_valid), 32'd0);
    xact(1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er); chk("rstreq_no_write", rd, 32'h0);

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal_f3[$urandom_range(0, we ? 2 : 4)];
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h400;
      else addr = 32'($urandom_range(0, 127));
      xact(we, f3, addr, $urandom, int'($urandom_range(0, 3)), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
